// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states and repeat-count width.
package serial_pattern_tx_pkg;

  localparam int unsigned REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit hold timer: strobes bit_tick on the last of every HOLD cycles while run is high.
module tx_bit_timer #(
  parameter int unsigned HOLD = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(HOLD) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  // With HOLD=1 the tick fires every running cycle, so hold_cnt never leaves 0.
  assign bit_tick = run && (hold_cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (start || abort || bit_tick) begin
      hold_cnt <= '0;
    end else if (run) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded word out LSB-first on `a`, repeated load_count+1 times.
// Optional even-parity slot after each word when SERIAL_PATTERN_TX_PARITY_EN is defined.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HOLD       = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [REP_W-1:0] load_count,
  input  logic             abort,
  output logic             a,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] data;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] next_idx;
  logic [REP_W-1:0] rep_cnt;
  logic             accept;
  logic             run;
  logic             bit_tick;
  logic             word_end;

  assign load_ready = (state == ST_IDLE);
  assign accept     = load_ready && load_valid;
  assign run        = (state != ST_IDLE);
  assign next_idx   = bit_idx + 1'b1;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign word_end = bit_tick && (state == ST_PARITY);
`else
  assign word_end = bit_tick && (bit_idx == LAST_IDX);
`endif

  tx_bit_timer #(.HOLD(HOLD)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (accept),
    .abort    (abort),
    .run      (run),
    .bit_tick (bit_tick)
  );

  // Priority when transmitting: abort, then end-of-word (repeat or finish), then bit advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      data    <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      a       <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (load_valid) begin
          data    <= load_data;
          rep_cnt <= load_count;
          bit_idx <= '0;
          a       <= load_data[0];
          busy    <= 1'b1;
          state   <= ST_SHIFT;
        end
      end else if (abort) begin
        state <= ST_IDLE;
        a     <= IDLE_LEVEL;
        busy  <= 1'b0;
      end else if (word_end) begin
        if (rep_cnt != '0) begin
          rep_cnt <= rep_cnt - 1'b1;
          bit_idx <= '0;
          a       <= data[0];
          state   <= ST_SHIFT;
        end else begin
          state <= ST_IDLE;
          a     <= IDLE_LEVEL;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (bit_tick) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        if (bit_idx == LAST_IDX) begin
          state <= ST_PARITY;
          a     <= ^data;
        end else
`endif
        begin
          bit_idx <= next_idx;
          a       <= data[next_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (HOLD=1, HOLD=2) share stimulus; table vectors,
// corner sequences and a queue-based reference model under random traffic.
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic [3:0] load_count;
  logic       abort;
  logic       a1, busy1, done1, rdy1;
  logic       a2, busy2, done2, rdy2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  serial_pattern_tx #(.WIDTH(4), .HOLD(1), .IDLE_LEVEL(1'b0)) dut1 (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy1),
    .load_data(load_data), .load_count(load_count), .abort(abort),
    .a(a1), .busy(busy1), .done(done1)
  );

  serial_pattern_tx #(.WIDTH(4), .HOLD(2), .IDLE_LEVEL(1'b0)) dut2 (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(rdy2),
    .load_data(load_data), .load_count(load_count), .abort(abort),
    .a(a2), .busy(busy2), .done(done2)
  );

  typedef struct {
    int          which;
    logic [3:0]  d;
    logic [3:0]  c;
    int          n;
    logic [63:0] w;
  } vec_t;

  vec_t tbl [6];

  // Reference model: expected `a` sequence per instance, played from a buffer.
  bit mbuf [2][512];
  int mhead [2];
  int mlen  [2];
  bit mdone [2];

  // Output tuple is {a, busy, done, load_ready}.
  function automatic logic [3:0] outs(input int which);
    return (which == 1) ? {a1, busy1, done1, rdy1} : {a2, busy2, done2, rdy2};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(rdy1 && rdy2) && k < 500) begin
      tick();
      k++;
    end
    if (!(rdy1 && rdy2)) chk("idle_timeout", {2'b00, rdy1, rdy2}, 4'b0011);
    tick();
  endtask

  task automatic run_wave(input int which, input logic [3:0] d, input logic [3:0] c,
                          input int n, input logic [63:0] w, input string tag);
    load_data  = d;
    load_count = c;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), outs(which), {w[i], 1'b1, 1'b0, 1'b0});
      tick();
    end
    chk({tag, "_done"}, outs(which), 4'b0011);
    tick();
    chk({tag, "_after"}, outs(which), 4'b0001);
    wait_idle();
  endtask

  function automatic void model_step(input int k, input int h, input bit lv,
                                     input logic [3:0] d, input logic [3:0] c, input bit ab);
    if (mhead[k] < mlen[k]) begin
      if (ab) begin
        mhead[k] = mlen[k];
        mdone[k] = 1'b0;
      end else begin
        mhead[k]++;
        mdone[k] = (mhead[k] == mlen[k]);
      end
    end else begin
      mdone[k] = 1'b0;
      if (lv) begin
        mhead[k] = 0;
        mlen[k]  = 0;
        for (int r = 0; r <= int'(c); r++) begin
          for (int b = 0; b < 4; b++)
            for (int t = 0; t < h; t++) begin
              mbuf[k][mlen[k]] = d[b];
              mlen[k]++;
            end
          for (int t = 0; t < h * PAR; t++) begin
            mbuf[k][mlen[k]] = ^d;
            mlen[k]++;
          end
        end
      end
    end
  endfunction

  function automatic logic [3:0] mexp(input int k);
    bit b;
    b = (mhead[k] < mlen[k]);
    return {b ? mbuf[k][mhead[k]] : 1'b0, b, mdone[k], !b};
  endfunction

  initial begin
    bit         lv, ab;
    logic [3:0] d, c;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    tbl[0] = '{2, 4'b1011, 4'd0, 10, 64'h3CF};
    tbl[1] = '{1, 4'b0110, 4'd2, 15, 64'h18C6};
    tbl[2] = '{1, 4'b0111, 4'd0,  5, 64'h17};
    tbl[3] = '{1, 4'b1000, 4'd1, 10, 64'h318};
    tbl[4] = '{1, 4'b0000, 4'd0,  5, 64'h0};
    tbl[5] = '{2, 4'b0110, 4'd1, 20, 64'hF03C};
`else
    tbl[0] = '{2, 4'b1011, 4'd0,  8, 64'hCF};
    tbl[1] = '{1, 4'b0110, 4'd2, 12, 64'h666};
    tbl[2] = '{1, 4'b0111, 4'd0,  4, 64'h7};
    tbl[3] = '{1, 4'b1000, 4'd1,  8, 64'h88};
    tbl[4] = '{1, 4'b0000, 4'd0,  4, 64'h0};
    tbl[5] = '{2, 4'b0110, 4'd1, 16, 64'h3C3C};
`endif

    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_count = '0;
    abort      = 1'b0;
    #12;
    chk("reset_h1", outs(1), 4'b0001);
    chk("reset_h2", outs(2), 4'b0001);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      run_wave(tbl[i].which, tbl[i].d, tbl[i].c, tbl[i].n, tbl[i].w, $sformatf("tbl%0d", i));

    // load_valid held with a new word through a transfer: taken only in the done cycle.
    load_data  = 4'b0110;
    load_count = 4'd0;
    load_valid = 1'b1;
    tick();
    load_data = 4'b1111;
    for (int i = 0; i < 4 + PAR; i++) begin
      chk($sformatf("held_cyc%0d", i), outs(1), {i == 1 || i == 2, 1'b1, 1'b0, 1'b0});
      tick();
    end
    chk("held_done", outs(1), 4'b0011);
    tick();
    chk("held_next_bit0", outs(1), 4'b1100);
    load_valid = 1'b0;
    wait_idle();

    // Abort sampled at the end of cycle 3 of a HOLD=2 transfer.
    load_data  = 4'b1011;
    load_count = 4'd0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre", outs(2), 4'b1100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_edge", outs(2), 4'b0001);
    tick();
    chk("abort_no_done", outs(2), 4'b0001);
    wait_idle();

    // Asynchronous reset mid-bit, then a fresh transfer from bit0.
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_h1", outs(1), 4'b0001);
    chk("async_rst_h2", outs(2), 4'b0001);
    #1 reset_n = 1'b1;
    tick();
    chk("post_rst_idle", outs(2), 4'b0001);
    run_wave(2, 4'b0111, 4'd0, 8 + 2 * PAR, (PAR != 0) ? 64'h33F : 64'h3F, "restart");

    // Random traffic against the reference model.
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0;
      mlen[k]  = 0;
      mdone[k] = 1'b0;
    end
    for (int i = 0; i < 800; i++) begin
      lv = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 25) == 0);
      d  = 4'($urandom);
      c  = 4'($urandom_range(0, 2));
      load_valid = lv;
      abort      = ab;
      load_data  = d;
      load_count = c;
      model_step(0, 1, lv, d, c, ab);
      model_step(1, 2, lv, d, c, ab);
      tick();
      chk($sformatf("rnd%0d_h1", i), outs(1), mexp(0));
      chk($sformatf("rnd%0d_h2", i), outs(2), mexp(1));
    end
    load_valid = 1'b0;
    abort      = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
